// File: rtl/mips_pkg.sv
// Shared word type, error-counter width, output-stage state encoding and counter helper
// for the operand select muxes.
package mips_pkg;

  localparam int WORD_W    = 32;
  localparam int ERR_CNT_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] err_cnt_sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    logic [ERR_CNT_W-1:0] nxt;
    if (cnt == {ERR_CNT_W{1'b1}}) begin
      nxt = cnt;
    end else begin
      nxt = cnt + ERR_CNT_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mux_sel_comb.sv
// Pure combinational NUM_IN:1 select with range check; an out-of-range select yields
// zero data and err=1, never an X from an out-of-bounds slice.
module mux_sel_comb
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = 4
) (
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_IN)-1:0] sel,
  output logic [WIDTH-1:0]          data,
  output logic                      err
);

  // Select the addressed input or flag the index as invalid.
  always_comb begin
    data = '0;
    err  = 1'b0;
    if (int'(sel) < NUM_IN) begin
      data = in_data[int'(sel)*WIDTH +: WIDTH];
      err  = 1'b0;
    end else begin
      data = '0;
      err  = 1'b1;
    end
  end

endmodule

// File: rtl/operand_mux_reg.sv
// NUM_IN:1 operand select with a registered valid/ready output stage and saturating error count.
// Define MUX_SKID_EN to add a one-entry skid register so in_ready comes straight from a flop.
module operand_mux_reg
  import mips_pkg::*;
#(
  parameter int WIDTH  = WORD_W,
  parameter int NUM_IN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [$clog2(NUM_IN)-1:0] in_sel,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_IN)-1:0] out_sel,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ERR_CNT_W-1:0]      err_cnt
);

  localparam int SEL_W = $clog2(NUM_IN);

  out_state_e             state_r;
  out_state_e             state_nxt_s;
  logic [WIDTH-1:0]       data_r;
  logic [SEL_W-1:0]       sel_r;
  logic                   err_r;
  logic [ERR_CNT_W-1:0]   err_cnt_r;
  logic [WIDTH-1:0]       mux_data_s;
  logic                   mux_err_s;
  logic                   accept_s;
  logic                   load_in_s;

  mux_sel_comb #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_sel (
    .in_data (in_data),
    .sel     (in_sel),
    .data    (mux_data_s),
    .err     (mux_err_s)
  );

`ifdef MUX_SKID_EN
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic [SEL_W-1:0] skid_sel_r;
  logic             skid_err_r;
  logic             load_skid_s;
  logic             skid_fill_s;

  assign in_ready = !skid_valid_r;
`else
  assign in_ready = !out_valid || out_ready;
`endif

  assign accept_s  = in_valid && in_ready;
  assign out_valid = (state_r == ST_FULL);
  assign out_data  = data_r;
  assign out_sel   = sel_r;
  assign out_err   = err_r;
  assign err_cnt   = err_cnt_r;

  // Next state and load controls for the output register (and skid when present).
  always_comb begin
    state_nxt_s = state_r;
    load_in_s   = 1'b0;
`ifdef MUX_SKID_EN
    load_skid_s = 1'b0;
    skid_fill_s = 1'b0;
`endif
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nxt_s = ST_FULL;
          load_in_s   = 1'b1;
        end else begin
          state_nxt_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_ready) begin
`ifdef MUX_SKID_EN
          // A parked beat always goes out before anything new; input is blocked meanwhile.
          if (skid_valid_r) begin
            load_skid_s = 1'b1;
          end else if (accept_s) begin
            load_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
`else
          if (accept_s) begin
            load_in_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
`endif
        end else begin
`ifdef MUX_SKID_EN
          skid_fill_s = accept_s;
`else
          state_nxt_s = ST_FULL;
`endif
        end
      end
      default: begin
        state_nxt_s = ST_EMPTY;
      end
    endcase
  end

  // Output stage state and held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EMPTY;
      data_r  <= '0;
      sel_r   <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (load_in_s) begin
        data_r <= mux_data_s;
        sel_r  <= in_sel;
        err_r  <= mux_err_s;
      end
`ifdef MUX_SKID_EN
      else if (load_skid_s) begin
        data_r <= skid_data_r;
        sel_r  <= skid_sel_r;
        err_r  <= skid_err_r;
      end
`endif
    end
  end

`ifdef MUX_SKID_EN
  // Skid entry: catches the beat accepted while the output is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_sel_r   <= '0;
      skid_err_r   <= 1'b0;
    end else begin
      if (skid_fill_s) begin
        skid_valid_r <= 1'b1;
        skid_data_r  <= mux_data_s;
        skid_sel_r   <= in_sel;
        skid_err_r   <= mux_err_s;
      end else if (load_skid_s) begin
        skid_valid_r <= 1'b0;
      end
    end
  end
`endif

  // Saturating count of accepted out-of-range beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_r <= '0;
    end else if (accept_s && mux_err_s) begin
      err_cnt_r <= err_cnt_sat_inc(err_cnt_r);
    end
  end

endmodule

// File: tb/tb_operand_mux_reg.sv
// Self-checking bench for operand_mux_reg: a NUM_IN=4 and a NUM_IN=3 instance side by side,
// each shadowed by a small FIFO model of outstanding results; honours MUX_SKID_EN.
`timescale 1ns/1ps
module tb_operand_mux_reg;
  import mips_pkg::*;

`ifdef MUX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic [1:0]   sel;
    logic         err;
  } beat_t;

  typedef struct packed {
    logic         inst;
    logic [1:0]   sel;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][4*W-1:0] in_data;
  logic [1:0][1:0]     in_sel;
  logic [1:0]          in_valid, in_ready, out_valid, out_ready, out_err;
  logic [1:0][W-1:0]   out_data;
  logic [1:0][1:0]     out_sel;
  logic [1:0][7:0]     err_cnt;

  always #5 clk = ~clk;

  operand_mux_reg #(.WIDTH(W), .NUM_IN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[0]), .in_sel(in_sel[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
    .out_sel(out_sel[0]), .out_err(out_err[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .err_cnt(err_cnt[0])
  );

  operand_mux_reg #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[1][3*W-1:0]), .in_sel(in_sel[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
    .out_sel(out_sel[1]), .out_err(out_err[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .err_cnt(err_cnt[1])
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference state: results still owed by each instance, oldest first.
  beat_t mq [2][2];
  int    mcnt [2];
  int    merr [2];
  int    n_acc [2];
  int    dut_acc [2];
  int    dut_drn [2];
  logic [1:0] act_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int num_in(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic beat_t ref_beat(input int i);
    beat_t b;
    int    s;
    s     = int'(in_sel[i]);
    b.sel = in_sel[i];
    if (s < num_in(i)) begin
      b.data = in_data[i][s*W +: W];
      b.err  = 1'b0;
    end else begin
      b.data = '0;
      b.err  = 1'b1;
    end
    return b;
  endfunction

  task automatic set_idle();
    in_valid  = 2'b00;
    out_ready = 2'b11;
  endtask

  task automatic check_outputs(input int i);
    chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(mcnt[i] > 0));
    if (mcnt[i] > 0) begin
      chk($sformatf("out_data[%0d]", i), 64'(out_data[i]), 64'(mq[i][0].data));
      chk($sformatf("out_sel[%0d]", i), 64'(out_sel[i]), 64'(mq[i][0].sel));
      chk($sformatf("out_err[%0d]", i), 64'(out_err[i]), 64'(mq[i][0].err));
    end
    chk($sformatf("err_cnt[%0d]", i), 64'(err_cnt[i]), 64'(merr[i]));
  endtask

  // One clock: check handshake against the model, advance the model, check registered outputs.
  task automatic cycle();
    logic exp_rdy, drn, acc;
    #1;
    for (int i = 0; i < 2; i++) begin
      exp_rdy = SKID ? (mcnt[i] < 2) : ((mcnt[i] == 0) || out_ready[i]);
      chk($sformatf("in_ready[%0d]", i), 64'(in_ready[i]), 64'(exp_rdy));
      act_acc[i] = in_valid[i] && in_ready[i];
      if (act_acc[i]) dut_acc[i]++;
      if (out_valid[i] && out_ready[i]) dut_drn[i]++;
      drn = (mcnt[i] > 0) && out_ready[i];
      acc = in_valid[i] && exp_rdy;
      if (drn) begin
        mq[i][0] = mq[i][1];
        mcnt[i]--;
      end
      if (acc) begin
        mq[i][mcnt[i]] = ref_beat(i);
        if (mq[i][mcnt[i]].err && merr[i] < 255) merr[i]++;
        mcnt[i]++;
        n_acc[i]++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) check_outputs(i);
  endtask

  // Asynchronous reset applied away from the clock edge, released on the falling edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_out_valid[%0d]", i), 64'(out_valid[i]), 64'd0);
      chk($sformatf("rst_out_data[%0d]", i), 64'(out_data[i]), 64'd0);
      chk($sformatf("rst_out_sel[%0d]", i), 64'(out_sel[i]), 64'd0);
      chk($sformatf("rst_out_err[%0d]", i), 64'(out_err[i]), 64'd0);
      chk($sformatf("rst_err_cnt[%0d]", i), 64'(err_cnt[i]), 64'd0);
      mcnt[i] = 0; merr[i] = 0; n_acc[i] = 0; dut_acc[i] = 0; dut_drn[i] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready[%0d]", i), 64'(in_ready[i]), 64'd1);
    end
  endtask

  localparam logic [W-1:0] DA = 32'hAAAA_0001;
  localparam logic [W-1:0] DB = 32'hBBBB_0002;
  localparam logic [W-1:0] DC = 32'hCCCC_0003;
  localparam logic [W-1:0] DD = 32'hDDDD_0004;

  initial begin
    vec_t vecs [7];
    int   n_bp, n_a, n_v, cyc;

    rst_n    = 1'b0;
    in_data  = '0;
    in_sel   = '0;
    set_idle();
    apply_reset();

    // Directed selects with expected results written out by hand.
    vecs[0] = '{inst: 1'b0, sel: 2'd2, exp_data: DC,    exp_err: 1'b0};
    vecs[1] = '{inst: 1'b0, sel: 2'd0, exp_data: DA,    exp_err: 1'b0};
    vecs[2] = '{inst: 1'b0, sel: 2'd3, exp_data: DD,    exp_err: 1'b0};
    vecs[3] = '{inst: 1'b0, sel: 2'd1, exp_data: DB,    exp_err: 1'b0};
    vecs[4] = '{inst: 1'b1, sel: 2'd2, exp_data: DC,    exp_err: 1'b0};
    vecs[5] = '{inst: 1'b1, sel: 2'd3, exp_data: 32'd0, exp_err: 1'b1};
    vecs[6] = '{inst: 1'b1, sel: 2'd0, exp_data: DA,    exp_err: 1'b0};
    for (int v = 0; v < 7; v++) begin
      set_idle();
      in_data[0] = {DD, DC, DB, DA};
      in_data[1] = {32'd0, DC, DB, DA};
      in_sel[vecs[v].inst]   = vecs[v].sel;
      in_valid[vecs[v].inst] = 1'b1;
      cycle();
      chk($sformatf("tbl%0d_valid", v), 64'(out_valid[vecs[v].inst]), 64'd1);
      chk($sformatf("tbl%0d_data", v), 64'(out_data[vecs[v].inst]), 64'(vecs[v].exp_data));
      chk($sformatf("tbl%0d_err", v), 64'(out_err[vecs[v].inst]), 64'(vecs[v].exp_err));
    end
    set_idle();
    cycle();
    chk("tbl_err_cnt", 64'(err_cnt[1]), 64'd1);

    // 300 out-of-range beats on the 3-input instance: counter must stop at 255.
    in_valid[1] = 1'b1;
    in_sel[1]   = 2'd3;
    for (int k = 0; k < 300; k++) begin
      in_data[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
      cycle();
    end
    chk("err_cnt_sat", 64'(err_cnt[1]), 64'd255);
    set_idle();
    cycle();

    // Back-pressure: consumer stalled for 5 cycles while the producer keeps offering.
    n_bp = 0;
    for (int k = 0; k < 5; k++) begin
      in_data[0]   = {4{32'h5000_0000 + 32'(k)}};
      in_sel[0]    = 2'(k);
      in_valid[0]  = 1'b1;
      out_ready[0] = 1'b0;
      cycle();
      n_bp += int'(act_acc[0]);
    end
    chk("bp_accepts", 64'(n_bp), SKID ? 64'd2 : 64'd1);
    chk("bp_hold", 64'(out_data[0]), 64'h5000_0000);
    chk("bp_in_ready", 64'(in_ready[0]), 64'd0);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    cycle();
    chk("bp_order", {31'd0, out_valid[0], (out_valid[0] ? out_data[0] : 32'd0)},
        SKID ? {31'd0, 1'b1, 32'h5000_0001} : 64'd0);
    cycle();

    // Streaming 16 beats with sel cycling: one accept and one valid result every cycle.
    n_a = 0;
    n_v = 0;
    for (int k = 0; k < 16; k++) begin
      in_data[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_sel[0]   = 2'(k);
      in_valid[0] = 1'b1;
      cycle();
      n_a += int'(act_acc[0]);
      n_v += int'(out_valid[0]);
    end
    chk("stream_accepts", 64'(n_a), 64'd16);
    chk("stream_valid", 64'(n_v), 64'd16);
    set_idle();
    cycle();

    // Reset in the middle of a stalled stream drops everything held.
    in_valid  = 2'b11;
    out_ready = 2'b00;
    in_sel[1] = 2'd3;
    repeat (3) cycle();
    apply_reset();
    set_idle();
    cycle();

    // Random valid/ready traffic on both instances against the model.
    cyc = 0;
    while ((n_acc[0] < 10000 || n_acc[1] < 10000) && cyc < 50000) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = ($urandom_range(3, 0) != 0);
        out_ready[i] = ($urandom_range(3, 0) != 0);
        in_sel[i]    = 2'($urandom());
        in_data[i]   = {$urandom(), $urandom(), $urandom(), $urandom()};
      end
      cycle();
      cyc++;
    end
    chk("rand_budget0", 64'(n_acc[0] >= 10000), 64'd1);
    chk("rand_budget1", 64'(n_acc[1] >= 10000), 64'd1);
    set_idle();
    repeat (4) cycle();
    chk("rand_conserve0", 64'(dut_drn[0]), 64'(dut_acc[0]));
    chk("rand_conserve1", 64'(dut_drn[1]), 64'(dut_acc[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
